exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- Execute stage of the KCP53K 64-bit RISC-V-style integer pipeline, between decode/register-read and memory.
- Computes one ALU result per instruction from two 64-bit operands under one-hot-style function enables.
- Registers the result as the memory address/writeback value, alongside store data and control, for the next stage.
- Holds its pipeline register while the downstream stage asserts busy.

Parameters:
- None.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  asynchronous reset, active-low (0 = reset)
- inpa_i  in  64  operand A
- inpb_i  in  64  operand B
- invB_i  in  1  use ~inpb_i as B' for add/and/xor/compare
- cflag_i  in  1  carry-in for sum; fill bit for right shift
- lsh_en_i  in  1  enable left shift term
- rsh_en_i  in  1  enable right shift term
- ltu_en_i  in  1  enable unsigned less-than term
- lts_en_i  in  1  enable signed less-than term
- sum_en_i  in  1  enable sum term
- and_en_i  in  1  enable AND term
- xor_en_i  in  1  enable XOR term
- rd_i  in  5  destination register index
- we_i  in  1  store (memory write) request
- nomem_i  in  1  non-memory instruction, result goes directly to writeback
- mem_i  in  1  memory access instruction
- dat_i  in  64  store data
- xrs_rwe_i  in  3  memory access size/sign-extension code, passed through
- busy_i  in  1  downstream stall
- rd_o  out  5  registered rd_i
- addr_o  out  64  registered ALU result (address or writeback value)
- we_o  out  1  registered we_i
- nomem_o  out  1  registered nomem_i
- mem_o  out  1  registered mem_i
- dat_o  out  64  registered dat_i
- xrs_rwe_o  out  3  registered xrs_rwe_i

Behaviour:
- B' = invB_i ? ~inpb_i : inpb_i.
- sum = inpa_i + B' + cflag_i, taken modulo 2^64. carry = bit 64 of the 65-bit sum.
- ltu = ~carry. This gives A<B unsigned when invB_i=1 and cflag_i=1.
- lts = (inpa_i[63] != inpb_i[63]) ? inpa_i[63] : sum[63].
- and = inpa_i & B'. xor = inpa_i ^ B'.
- Shift amount = inpb_i[5:0], never inverted.
- lsh = inpa_i << amt.
- rsh = inpa_i >> amt, with vacated upper bits filled by cflag_i (cflag_i=1 gives arithmetic fill of all ones; the decoder drives cflag_i=inpa_i[63] for SRA).
- result = OR of all enabled terms: sum, and, xor, lsh, rsh, {63'b0,ltu}, {63'b0,lts}.
- No enable asserted gives result 0.
- OR is obtained by asserting and_en_i and xor_en_i together ((a&b)|(a^b) = a|b).
- Pipeline register: on rising clk_i with busy_i=0, all outputs load (addr_o <= result, others <= matching inputs). Latency is exactly 1 cycle.
- busy_i=1: all outputs hold their values. Inputs are ignored that cycle.
- reset_i=0: immediately, asynchronously, all outputs go to 0 (addr_o, dat_o, rd_o, xrs_rwe_o, we_o, nomem_o, mem_o). This overrides busy_i and applies mid-operation.
- Control bits pass through unmodified. Simultaneous mem_i and nomem_i are not checked or altered.
- ALU is purely combinational; no multi-cycle operations.

Test Plan:
- Reset: reset_i=0 with arbitrary nonzero inputs -> all outputs 0 without a clock edge. Release with all inputs 0 -> after one edge, addr_o=0.
- Add/sub: inpa=5, inpb=3, sum_en=1 -> addr_o=8 after one edge. Same operands with invB=1, cflag=1 -> addr_o=2. rd_i=7, xrs_rwe_i=3'b101, dat_i=0x1234 -> same values on rd_o, xrs_rwe_o and dat_o.
- Compare: inpa=0xFFFF_FFFF_FFFF_FFFF, inpb=1, invB=1, cflag=1: lts_en -> addr_o=1; ltu_en -> addr_o=0.
- Shifts: inpa=0x8000_0000_0000_0000, inpb=4, rsh_en: cflag=1 -> 0xF800_0000_0000_0000; cflag=0 -> 0x0800_0000_0000_0000. lsh_en with inpa=1, inpb=65 -> addr_o=2 (amount masked to 6 bits).
- Logic: inpa=0xF0, inpb=0x3C: and_en -> 0x30; xor_en -> 0xCC; both -> 0xFC.
- Stall: load addr_o=8, then busy_i=1 for 3 cycles while inputs change -> all outputs stay at prior values. busy_i=0 -> new result appears on the next edge. Assert reset_i=0 while busy_i=1 -> outputs clear immediately.

Source files
------------

// File: rtl/exec_stage.sv
// KCP53K execute stage: OR-combined ALU terms under per-term enables,
// registered into the memory-stage pipeline register with stall hold.
module exec_stage (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] inpa_i,
  input  logic [63:0] inpb_i,
  input  logic        invB_i,
  input  logic        cflag_i,
  input  logic        lsh_en_i,
  input  logic        rsh_en_i,
  input  logic        ltu_en_i,
  input  logic        lts_en_i,
  input  logic        sum_en_i,
  input  logic        and_en_i,
  input  logic        xor_en_i,
  input  logic [4:0]  rd_i,
  input  logic        we_i,
  input  logic        nomem_i,
  input  logic        mem_i,
  input  logic [63:0] dat_i,
  input  logic [2:0]  xrs_rwe_i,
  input  logic        busy_i,
  output logic [4:0]  rd_o,
  output logic [63:0] addr_o,
  output logic        we_o,
  output logic        nomem_o,
  output logic        mem_o,
  output logic [63:0] dat_o,
  output logic [2:0]  xrs_rwe_o
);

  logic [63:0] w_b;
  logic [64:0] w_sum_full;
  logic [63:0] w_sum;
  logic        w_ltu;
  logic        w_lts;
  logic [5:0]  w_amt;
  logic [63:0] w_lsh;
  logic [64:0] w_rsh_ext;
  logic [63:0] w_rsh;
  logic [63:0] w_result;

  logic [4:0]  r_rd;
  logic [63:0] r_addr;
  logic        r_we;
  logic        r_nomem;
  logic        r_mem;
  logic [63:0] r_dat;
  logic [2:0]  r_xrs_rwe;

  assign w_b        = invB_i ? ~inpb_i : inpb_i;
  assign w_sum_full = {1'b0, inpa_i} + {1'b0, w_b} + {64'd0, cflag_i};
  assign w_sum      = w_sum_full[63:0];
  assign w_ltu      = ~w_sum_full[64];
  assign w_lts      = (inpa_i[63] != inpb_i[63]) ? inpa_i[63] : w_sum[63];

  // Shift amount uses raw operand B; prepending cflag_i makes the arithmetic
  // shift fill vacated bits with cflag_i.
  assign w_amt      = inpb_i[5:0];
  assign w_lsh      = inpa_i << w_amt;
  assign w_rsh_ext  = $signed({cflag_i, inpa_i}) >>> w_amt;
  assign w_rsh      = w_rsh_ext[63:0];

  always_comb begin
    w_result = '0;
    if (sum_en_i) w_result = w_result | w_sum;
    if (and_en_i) w_result = w_result | (inpa_i & w_b);
    if (xor_en_i) w_result = w_result | (inpa_i ^ w_b);
    if (lsh_en_i) w_result = w_result | w_lsh;
    if (rsh_en_i) w_result = w_result | w_rsh;
    if (ltu_en_i) w_result = w_result | {63'd0, w_ltu};
    if (lts_en_i) w_result = w_result | {63'd0, w_lts};
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rd      <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_nomem   <= 1'b0;
      r_mem     <= 1'b0;
      r_dat     <= '0;
      r_xrs_rwe <= '0;
    end else if (!busy_i) begin
      r_rd      <= rd_i;
      r_addr    <= w_result;
      r_we      <= we_i;
      r_nomem   <= nomem_i;
      r_mem     <= mem_i;
      r_dat     <= dat_i;
      r_xrs_rwe <= xrs_rwe_i;
    end
  end

  assign rd_o      = r_rd;
  assign addr_o    = r_addr;
  assign we_o      = r_we;
  assign nomem_o   = r_nomem;
  assign mem_o     = r_mem;
  assign dat_o     = r_dat;
  assign xrs_rwe_o = r_xrs_rwe;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed steps plus randomized cycles
// against a bit-level reference of the ALU rules and pipeline register.
module tb_exec_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] inpa_i, inpb_i, dat_i;
  logic        invB_i, cflag_i;
  logic        lsh_en_i, rsh_en_i, ltu_en_i, lts_en_i, sum_en_i, and_en_i, xor_en_i;
  logic [4:0]  rd_i;
  logic        we_i, nomem_i, mem_i;
  logic [2:0]  xrs_rwe_i;
  logic        busy_i;

  logic [4:0]  rd_o;
  logic [63:0] addr_o, dat_o;
  logic        we_o, nomem_o, mem_o;
  logic [2:0]  xrs_rwe_o;

  int checks = 0;
  int errors = 0;

  logic [4:0]  e_rd;
  logic [63:0] e_addr, e_dat;
  logic        e_we, e_nomem, e_mem;
  logic [2:0]  e_xrs;

  always #5 clk_i = ~clk_i;

  exec_stage dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .inpa_i(inpa_i), .inpb_i(inpb_i), .invB_i(invB_i), .cflag_i(cflag_i),
    .lsh_en_i(lsh_en_i), .rsh_en_i(rsh_en_i), .ltu_en_i(ltu_en_i),
    .lts_en_i(lts_en_i), .sum_en_i(sum_en_i), .and_en_i(and_en_i),
    .xor_en_i(xor_en_i), .rd_i(rd_i), .we_i(we_i), .nomem_i(nomem_i),
    .mem_i(mem_i), .dat_i(dat_i), .xrs_rwe_i(xrs_rwe_i), .busy_i(busy_i),
    .rd_o(rd_o), .addr_o(addr_o), .we_o(we_o), .nomem_o(nomem_o),
    .mem_o(mem_o), .dat_o(dat_o), .xrs_rwe_o(xrs_rwe_o)
  );

  // Reference ALU built bit by bit from the operation rules.
  function automatic logic [63:0] ref_alu();
    logic [63:0] a, bp, res, lsh, rsh;
    logic [64:0] full;
    logic        ltu, lts;
    int          amt, j;
    a    = inpa_i;
    bp   = invB_i ? ~inpb_i : inpb_i;
    full = 65'(a) + 65'(bp) + 65'(cflag_i);
    ltu  = ~full[64];
    lts  = (a[63] != inpb_i[63]) ? a[63] : full[63];
    amt  = int'(inpb_i % 64);
    for (int i = 0; i < 64; i++) begin
      j = i + amt;
      rsh[i] = (j < 64) ? a[j] : cflag_i;
      j = i - amt;
      lsh[i] = (j >= 0) ? a[j] : 1'b0;
    end
    res = 64'd0;
    if (sum_en_i) res |= full[63:0];
    if (and_en_i) res |= a & bp;
    if (xor_en_i) res |= a ^ bp;
    if (lsh_en_i) res |= lsh;
    if (rsh_en_i) res |= rsh;
    if (ltu_en_i) res |= {63'd0, ltu};
    if (lts_en_i) res |= {63'd0, lts};
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  addr_o,          e_addr);
    chk({tag, ".dat"},   dat_o,           e_dat);
    chk({tag, ".rd"},    64'(rd_o),       64'(e_rd));
    chk({tag, ".xrs"},   64'(xrs_rwe_o),  64'(e_xrs));
    chk({tag, ".we"},    64'(we_o),       64'(e_we));
    chk({tag, ".nomem"}, 64'(nomem_o),    64'(e_nomem));
    chk({tag, ".mem"},   64'(mem_o),      64'(e_mem));
  endtask

  task automatic clear_model();
    e_addr = '0; e_dat = '0; e_rd = '0; e_xrs = '0;
    e_we = 1'b0; e_nomem = 1'b0; e_mem = 1'b0;
  endtask

  task automatic clear_in();
    inpa_i = '0; inpb_i = '0; dat_i = '0; invB_i = 0; cflag_i = 0;
    lsh_en_i = 0; rsh_en_i = 0; ltu_en_i = 0; lts_en_i = 0;
    sum_en_i = 0; and_en_i = 0; xor_en_i = 0;
    rd_i = '0; we_i = 0; nomem_i = 0; mem_i = 0; xrs_rwe_i = '0; busy_i = 0;
  endtask

  task automatic clear_en();
    lsh_en_i = 0; rsh_en_i = 0; ltu_en_i = 0; lts_en_i = 0;
    sum_en_i = 0; and_en_i = 0; xor_en_i = 0; invB_i = 0; cflag_i = 0;
  endtask

  // One clock: predict from inputs held across the edge, sample 1 time unit after.
  task automatic cycle(input string tag);
    logic [63:0] p_addr;
    logic        stall;
    p_addr = ref_alu();
    stall  = busy_i;
    @(posedge clk_i);
    #1;
    if (!stall) begin
      e_addr = p_addr; e_dat = dat_i; e_rd = rd_i; e_xrs = xrs_rwe_i;
      e_we = we_i; e_nomem = nomem_i; e_mem = mem_i;
    end
    check_all(tag);
  endtask

  task automatic randomize_inputs();
    logic [6:0] en;
    inpa_i = {$urandom, $urandom};
    inpb_i = {$urandom, $urandom};
    dat_i  = {$urandom, $urandom};
    invB_i = 1'($urandom); cflag_i = 1'($urandom);
    en = 7'($urandom);
    if ($urandom_range(0, 1) == 0) en = 7'(1 << $urandom_range(0, 6));
    {lsh_en_i, rsh_en_i, ltu_en_i, lts_en_i, sum_en_i, and_en_i, xor_en_i} = en;
    rd_i = 5'($urandom); xrs_rwe_i = 3'($urandom);
    we_i = 1'($urandom); nomem_i = 1'($urandom); mem_i = 1'($urandom);
  endtask

  initial begin
    clear_in();
    clear_model();
    reset_i = 1'b1;

    // Load nonzero state, then assert reset away from any edge.
    inpa_i = 64'h1111; inpb_i = 64'h2222; sum_en_i = 1; rd_i = 5'h1f;
    dat_i = 64'hDEAD_BEEF; xrs_rwe_i = 3'b111; we_i = 1; nomem_i = 1; mem_i = 1;
    cycle("preload");
    chk("preload_const", addr_o, 64'h3333);
    #2 reset_i = 1'b0;
    #1 clear_model();
    check_all("async_reset");

    clear_in();
    #3 reset_i = 1'b1;
    cycle("release");
    chk("release_const", addr_o, 64'd0);

    inpa_i = 64'd5; inpb_i = 64'd3; sum_en_i = 1;
    rd_i = 5'd7; xrs_rwe_i = 3'b101; dat_i = 64'h1234;
    cycle("add");
    chk("add_const", addr_o, 64'd8);
    chk("add_rd", 64'(rd_o), 64'd7);
    chk("add_xrs", 64'(xrs_rwe_o), 64'd5);
    chk("add_dat", dat_o, 64'h1234);
    invB_i = 1; cflag_i = 1;
    cycle("sub");
    chk("sub_const", addr_o, 64'd2);

    clear_en();
    inpa_i = '1; inpb_i = 64'd1; invB_i = 1; cflag_i = 1; lts_en_i = 1;
    cycle("lts");
    chk("lts_const", addr_o, 64'd1);
    lts_en_i = 0; ltu_en_i = 1;
    cycle("ltu");
    chk("ltu_const", addr_o, 64'd0);

    clear_en();
    inpa_i = 64'h8000_0000_0000_0000; inpb_i = 64'd4; rsh_en_i = 1; cflag_i = 1;
    cycle("sra");
    chk("sra_const", addr_o, 64'hF800_0000_0000_0000);
    cflag_i = 0;
    cycle("srl");
    chk("srl_const", addr_o, 64'h0800_0000_0000_0000);
    clear_en();
    inpa_i = 64'd1; inpb_i = 64'd65; lsh_en_i = 1;
    cycle("sll_mask");
    chk("sll_const", addr_o, 64'd2);

    clear_en();
    inpa_i = 64'hF0; inpb_i = 64'h3C; and_en_i = 1;
    cycle("and");
    chk("and_const", addr_o, 64'h30);
    and_en_i = 0; xor_en_i = 1;
    cycle("xor");
    chk("xor_const", addr_o, 64'hCC);
    and_en_i = 1;
    cycle("or");
    chk("or_const", addr_o, 64'hFC);

    clear_en();
    inpa_i = 64'd5; inpb_i = 64'd3; sum_en_i = 1;
    cycle("stall_load");
    chk("stall_load_const", addr_o, 64'd8);
    busy_i = 1;
    for (int k = 0; k < 3; k++) begin
      randomize_inputs();
      cycle("stall_hold");
      chk("stall_hold_const", addr_o, 64'd8);
    end
    busy_i = 0;
    clear_en();
    inpa_i = 64'd100; inpb_i = 64'd23; sum_en_i = 1;
    cycle("stall_release");
    chk("stall_release_const", addr_o, 64'd123);
    busy_i = 1;
    #2 reset_i = 1'b0;
    #1 clear_model();
    check_all("reset_over_busy");
    clear_in();
    #3 reset_i = 1'b1;

    for (int k = 0; k < 300; k++) begin
      randomize_inputs();
      busy_i = ($urandom_range(0, 4) == 0);
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
